// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave answering full-width INCR bursts from an
// on-chip dual-port block RAM. Independent read and write state machines
// share one memory array. Each direction accepts one outstanding burst.
// Optional feature macro: AXI_MEM_RESP_RANGE_CHK_EN. When it is defined,
// word indices at or beyond C_MEM_DEPTH are rejected with SLVERR. When it
// is not defined, word indices wrap modulo C_MEM_DEPTH.
module axi_mem_responder #(
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_DATA_WIDTH = 512,
    parameter int C_ID_WIDTH   = 1,
    parameter int C_MEM_DEPTH  = 1024
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [C_ADDR_WIDTH-1:0]   awaddr,
    input  logic [C_ID_WIDTH-1:0]     awid,
    input  logic [7:0]                awlen,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [C_DATA_WIDTH-1:0]   wdata,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb,
    input  logic                      wlast,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    output logic [C_ID_WIDTH-1:0]     bid,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [C_ADDR_WIDTH-1:0]   araddr,
    input  logic [C_ID_WIDTH-1:0]     arid,
    input  logic [7:0]                arlen,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [C_DATA_WIDTH-1:0]   rdata,
    output logic                      rlast,
    output logic [C_ID_WIDTH-1:0]     rid,
    output logic [1:0]                rresp
);

    localparam int BYTES    = C_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = C_ADDR_WIDTH - ADDR_LSB;
    localparam int MEM_AW   = $clog2(C_MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rd_state_t;

    logic [C_DATA_WIDTH-1:0] mem_r [C_MEM_DEPTH];

    wr_state_t               wr_state_r;
    logic [IDX_W-1:0]        widx_r;
    logic [7:0]              wcnt_r;
    logic                    werr_r;
    logic                    awready_r;
    logic                    wready_r;
    logic                    bvalid_r;
    logic [1:0]              bresp_r;
    logic [C_ID_WIDTH-1:0]   bid_r;

    rd_state_t               rd_state_r;
    logic [IDX_W-1:0]        ridx_r;
    logic [7:0]              rcnt_r;
    logic                    arready_r;
    logic                    rvalid_r;
    logic                    rlast_r;
    logic [1:0]              rresp_r;
    logic [C_ID_WIDTH-1:0]   rid_r;
    logic [C_DATA_WIDTH-1:0] rdata_r;

    logic                    wr_beat_s;
    logic                    wr_en_s;
    logic                    wr_oor_s;
    logic                    rd_oor_s;

`ifdef AXI_MEM_RESP_RANGE_CHK_EN
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(C_MEM_DEPTH);
    assign wr_oor_s = (widx_r >= DEPTH_IDX);
    assign rd_oor_s = (ridx_r >= DEPTH_IDX);
    logic unused_s;
    assign unused_s = ^{wlast, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};
`else
    assign wr_oor_s = 1'b0;
    assign rd_oor_s = 1'b0;
    logic unused_s;
    assign unused_s = ^{wlast, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0],
                        widx_r[IDX_W-1:MEM_AW], ridx_r[IDX_W-1:MEM_AW]};
`endif

    // A write beat is accepted only while collecting data; out-of-range beats never touch memory.
    assign wr_beat_s = (wr_state_r == W_DATA) && wvalid && wready_r;
    assign wr_en_s   = wr_beat_s && !wr_oor_s;

    // Byte-enabled memory write port; the read port samples old data on a same-word collision.
    always_ff @(posedge ap_clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) begin
                    mem_r[widx_r[MEM_AW-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Write channel FSM: accept address, count beats (wlast is not trusted), then respond.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_state_r <= W_IDLE;
            widx_r     <= {IDX_W{1'b0}};
            wcnt_r     <= 8'd0;
            werr_r     <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            bid_r      <= {C_ID_WIDTH{1'b0}};
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (awvalid && awready_r) begin
                        widx_r     <= awaddr[C_ADDR_WIDTH-1:ADDR_LSB];
                        wcnt_r     <= awlen;
                        bid_r      <= awid;
                        werr_r     <= 1'b0;
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b1;
                        wr_state_r <= W_DATA;
                    end else begin
                        awready_r  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wr_beat_s) begin
                        widx_r <= widx_r + IDX_W'(1'b1);
                        werr_r <= werr_r | wr_oor_s;
                        if (wcnt_r == 8'd0) begin
                            wready_r   <= 1'b0;
                            bvalid_r   <= 1'b1;
                            bresp_r    <= (werr_r | wr_oor_s) ? RESP_SLVERR : RESP_OKAY;
                            wr_state_r <= W_RESP;
                        end else begin
                            wcnt_r <= wcnt_r - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_r   <= 1'b0;
                        awready_r  <= 1'b1;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    awready_r  <= 1'b0;
                    wready_r   <= 1'b0;
                    bvalid_r   <= 1'b0;
                    wr_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: one fetch cycle after AR, then the next word is loaded on every R handshake.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            rd_state_r <= R_IDLE;
            ridx_r     <= {IDX_W{1'b0}};
            rcnt_r     <= 8'd0;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rid_r      <= {C_ID_WIDTH{1'b0}};
            rdata_r    <= {C_DATA_WIDTH{1'b0}};
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (arvalid && arready_r) begin
                        ridx_r     <= araddr[C_ADDR_WIDTH-1:ADDR_LSB];
                        rcnt_r     <= arlen;
                        rid_r      <= arid;
                        arready_r  <= 1'b0;
                        rd_state_r <= R_FETCH;
                    end else begin
                        arready_r  <= 1'b1;
                    end
                end
                R_FETCH: begin
                    rdata_r    <= rd_oor_s ? {C_DATA_WIDTH{1'b0}} : mem_r[ridx_r[MEM_AW-1:0]];
                    rresp_r    <= rd_oor_s ? RESP_SLVERR : RESP_OKAY;
                    rlast_r    <= (rcnt_r == 8'd0);
                    rcnt_r     <= rcnt_r - 8'd1;
                    ridx_r     <= ridx_r + IDX_W'(1'b1);
                    rvalid_r   <= 1'b1;
                    rd_state_r <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_r) begin
                            rvalid_r   <= 1'b0;
                            rlast_r    <= 1'b0;
                            arready_r  <= 1'b1;
                            rd_state_r <= R_IDLE;
                        end else begin
                            rdata_r <= rd_oor_s ? {C_DATA_WIDTH{1'b0}} : mem_r[ridx_r[MEM_AW-1:0]];
                            rresp_r <= rd_oor_s ? RESP_SLVERR : RESP_OKAY;
                            rlast_r <= (rcnt_r == 8'd0);
                            rcnt_r  <= rcnt_r - 8'd1;
                            ridx_r  <= ridx_r + IDX_W'(1'b1);
                        end
                    end
                end
                default: begin
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                    rlast_r    <= 1'b0;
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign bid     = bid_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rlast   = rlast_r;
    assign rid     = rid_r;
    assign rresp   = rresp_r;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed testbench for axi_mem_responder with hand-computed expectations.
module tb_axi_mem_responder;

    logic         ap_clk = 1'b0;
    logic         areset;
    logic         awvalid, awready;
    logic [63:0]  awaddr;
    logic [0:0]   awid;
    logic [7:0]   awlen;
    logic         wvalid, wready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic [0:0]   bid;
    logic         arvalid, arready;
    logic [63:0]  araddr;
    logic [0:0]   arid;
    logic [7:0]   arlen;
    logic         rvalid, rready;
    logic [511:0] rdata;
    logic         rlast;
    logic [0:0]   rid;
    logic [1:0]   rresp;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Write stimulus and captured write results
    logic [511:0] wbeat [16];
    logic [63:0]  wstrb_beat [16];
    logic [1:0]   bresp_got;
    logic [0:0]   bid_got;
    logic         w_ready_next, b_next, aw_after;

    // Captured read results
    logic [511:0] rd_data [16];
    logic         rd_last [16];
    logic [1:0]   rd_resp [16];
    logic [0:0]   rd_id_got;
    int           rd_cnt, first_lat, stab_viol;
    logic         ar_after;

    axi_mem_responder dut (
        .ap_clk(ap_clk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rid(rid), .rresp(rresp)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id);
        int guard;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 50) begin @(posedge ap_clk); #1; guard++; end
        if (!awready) begin
            vec_cnt++; err_cnt++;
            $display("FAIL aw_timeout: awready got 0 expected 1");
            awvalid = 1'b0;
            return;
        end
        @(posedge ap_clk); #1;
        awvalid = 1'b0;
        w_ready_next = wready;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbeat[i]; wstrb = wstrb_beat[i]; wlast = (i == int'(len)); wvalid = 1'b1;
            guard = 0;
            while (!wready && guard < 50) begin @(posedge ap_clk); #1; guard++; end
            if (!wready) begin
                vec_cnt++; err_cnt++;
                $display("FAIL w_timeout: wready got 0 expected 1");
                wvalid = 1'b0;
                return;
            end
            @(posedge ap_clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        b_next = bvalid;
        bready = 1'b1;
        guard = 0;
        while (!bvalid && guard < 50) begin @(posedge ap_clk); #1; guard++; end
        if (!bvalid) begin
            vec_cnt++; err_cnt++;
            $display("FAIL b_timeout: bvalid got 0 expected 1");
            bready = 1'b0;
            return;
        end
        bresp_got = bresp; bid_got = bid;
        @(posedge ap_clk); #1;
        bready = 1'b0;
        aw_after = awready;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id,
                           input bit stall);
        int guard;
        bit done, held_v;
        logic [511:0] held_d;
        logic held_l;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 50) begin @(posedge ap_clk); #1; guard++; end
        if (!arready) begin
            vec_cnt++; err_cnt++;
            $display("FAIL ar_timeout: arready got 0 expected 1");
            arvalid = 1'b0;
            return;
        end
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        rd_cnt = 0; first_lat = 0; stab_viol = 0; done = 1'b0; held_v = 1'b0;
        held_d = 512'd0; held_l = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            rready = stall ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            if (rvalid && first_lat == 0) first_lat = c + 1;
            if (rvalid) begin
                if (held_v && (rdata !== held_d || rlast !== held_l)) stab_viol++;
                if (rready) begin
                    if (rd_cnt < 16) begin
                        rd_data[rd_cnt] = rdata; rd_last[rd_cnt] = rlast; rd_resp[rd_cnt] = rresp;
                    end
                    if (rd_cnt == 0) rd_id_got = rid;
                    rd_cnt++;
                    held_v = 1'b0;
                    if (rlast) done = 1'b1;
                end else begin
                    held_d = rdata; held_l = rlast; held_v = 1'b1;
                end
            end
            @(posedge ap_clk); #1;
        end
        rready = 1'b0;
        ar_after = arready;
        if (!done) begin
            vec_cnt++; err_cnt++;
            $display("FAIL r_timeout: rlast beat got none expected one");
        end
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        vec_cnt++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b expected 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        end
        vec_cnt++;
        if ({bresp, rresp, bid, rid} !== 6'b0) begin
            err_cnt++;
            $display("FAIL reset_resp: got %b expected 000000", {bresp, rresp, bid, rid});
        end
        vec_cnt++;
        if (rdata !== 512'd0) begin
            err_cnt++;
            $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        areset = 1'b0;
        @(posedge ap_clk); #1;
        vec_cnt++;
        if ({awready, arready} !== 2'b11) begin
            err_cnt++;
            $display("FAIL ready_after_reset: got %b expected 11", {awready, arready});
        end
    endtask

    task automatic test_burst;
        for (int i = 0; i < 4; i++) begin
            wbeat[i] = 512'(i + 1); wstrb_beat[i] = {64{1'b1}};
        end
        do_write(64'h0, 8'd3, 1'b1);
        vec_cnt++;
        if ({bresp_got, bid_got} !== 3'b001) begin
            err_cnt++;
            $display("FAIL burst_bresp_bid: got %b expected 001", {bresp_got, bid_got});
        end
        vec_cnt++;
        if ({w_ready_next, b_next, aw_after} !== 3'b111) begin
            err_cnt++;
            $display("FAIL write_timing: got %b expected 111", {w_ready_next, b_next, aw_after});
        end
        do_read(64'h0, 8'd3, 1'b1, 1'b0);
        vec_cnt++;
        if (rd_cnt !== 4) begin
            err_cnt++;
            $display("FAIL burst_beats: got %0d expected 4", rd_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (rd_data[i] !== 512'(i + 1) || rd_resp[i] !== 2'b00) begin
                err_cnt++;
                $display("FAIL burst_data[%0d]: got %h/%b expected %0d/00", i, rd_data[i], rd_resp[i], i + 1);
            end
        end
        vec_cnt++;
        if ({rd_last[3], rd_last[2], rd_last[1], rd_last[0]} !== 4'b1000) begin
            err_cnt++;
            $display("FAIL burst_rlast: got %b expected 1000", {rd_last[3], rd_last[2], rd_last[1], rd_last[0]});
        end
        vec_cnt++;
        if (first_lat !== 2) begin
            err_cnt++;
            $display("FAIL read_latency: got %0d expected 2", first_lat);
        end
        vec_cnt++;
        if ({rd_id_got, ar_after} !== 2'b11) begin
            err_cnt++;
            $display("FAIL rid_arready: got %b expected 11", {rd_id_got, ar_after});
        end
    endtask

    task automatic test_strobe;
        logic [511:0] exp;
        wbeat[0] = {512{1'b1}}; wstrb_beat[0] = {64{1'b1}};
        do_write(64'd640, 8'd0, 1'b0);
        wbeat[0] = {16{32'h1122_3344}}; wstrb_beat[0] = 64'h0000_0000_0000_000F;
        do_write(64'd640, 8'd0, 1'b0);
        do_read(64'd640, 8'd0, 1'b0, 1'b0);
        exp = {512{1'b1}};
        exp[31:0] = 32'h1122_3344;
        vec_cnt++;
        if (rd_cnt !== 1 || rd_data[0] !== exp || rd_last[0] !== 1'b1) begin
            err_cnt++;
            $display("FAIL strobe_merge: got %0d beats %h expected 1 beat %h", rd_cnt, rd_data[0], exp);
        end
    endtask

    task automatic test_read_stall;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 16; j++) wbeat[i][j*32 +: 32] = 32'hC0DE_0000 + 32'(i);
            wstrb_beat[i] = {64{1'b1}};
        end
        do_write(64'h1000, 8'd7, 1'b0);
        do_read(64'h1000, 8'd7, 1'b0, 1'b1);
        vec_cnt++;
        if (rd_cnt !== 8 || stab_viol !== 0) begin
            err_cnt++;
            $display("FAIL stall_beats: got %0d beats %0d unstable expected 8 beats 0 unstable", rd_cnt, stab_viol);
        end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (rd_data[i] !== {16{32'hC0DE_0000 + 32'(i)}} || rd_last[i] !== (i == 7)) begin
                err_cnt++;
                $display("FAIL stall_data[%0d]: got %h last %b", i, rd_data[i], rd_last[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [511:0] pat_a, pat_b, pat_c;
        pat_a = {16{32'hAAAA_5555}}; pat_b = {16{32'hBBBB_6666}}; pat_c = {16{32'h0C0C_0C0C}};
        wbeat[0] = pat_c; wstrb_beat[0] = {64{1'b1}};
        do_write(64'h0, 8'd0, 1'b0);
        wbeat[0] = pat_a; wbeat[1] = pat_b; wstrb_beat[1] = {64{1'b1}};
        do_write(64'h0000_FFC0, 8'd1, 1'b0);
        do_read(64'h0, 8'd0, 1'b0, 1'b0);
`ifdef AXI_MEM_RESP_RANGE_CHK_EN
        vec_cnt++;
        if (bresp_got !== 2'b10) begin
            err_cnt++;
            $display("FAIL range_bresp: got %b expected 10", bresp_got);
        end
        vec_cnt++;
        if (rd_data[0] !== pat_c) begin
            err_cnt++;
            $display("FAIL range_word0: got %h expected %h", rd_data[0], pat_c);
        end
        do_read(64'h0000_FFC0, 8'd1, 1'b0, 1'b0);
        vec_cnt++;
        if (rd_data[0] !== pat_a || rd_data[1] !== 512'd0 || {rd_resp[0], rd_resp[1]} !== 4'b0010) begin
            err_cnt++;
            $display("FAIL range_read: got resp %b%b expected 0010", rd_resp[0], rd_resp[1]);
        end
`else
        vec_cnt++;
        if (bresp_got !== 2'b00) begin
            err_cnt++;
            $display("FAIL wrap_bresp: got %b expected 00", bresp_got);
        end
        vec_cnt++;
        if (rd_data[0] !== pat_b) begin
            err_cnt++;
            $display("FAIL wrap_word0: got %h expected %h", rd_data[0], pat_b);
        end
        do_read(64'h0000_FFC0, 8'd1, 1'b0, 1'b0);
        vec_cnt++;
        if (rd_data[0] !== pat_a || rd_data[1] !== pat_b || {rd_resp[0], rd_resp[1]} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL wrap_read: got resp %b%b expected 0000", rd_resp[0], rd_resp[1]);
        end
`endif
    endtask

    task automatic test_reset_mid_read;
        int guard, beats;
        for (int i = 0; i < 8; i++) begin
            wbeat[i] = {16{32'h5EED_0000 + 32'(i)}}; wstrb_beat[i] = {64{1'b1}};
        end
        do_write(64'h2000, 8'd7, 1'b0);
        araddr = 64'h2000; arlen = 8'd7; arid = 1'b0; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 50) begin @(posedge ap_clk); #1; guard++; end
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        beats = 0; guard = 0;
        while (beats < 2 && guard < 50) begin
            if (rvalid) beats++;
            @(posedge ap_clk); #1;
            guard++;
        end
        vec_cnt++;
        if (rvalid !== 1'b1 || rdata !== {16{32'h5EED_0002}}) begin
            err_cnt++;
            $display("FAIL mid_beat3: got valid %b data %h expected 1 and word 2", rvalid, rdata);
        end
        areset = 1'b1;
        rready = 1'b0;
        @(posedge ap_clk); #1;
        vec_cnt++;
        if ({rvalid, arready, bvalid} !== 3'b000) begin
            err_cnt++;
            $display("FAIL mid_reset: got %b expected 000", {rvalid, arready, bvalid});
        end
        areset = 1'b0;
        @(posedge ap_clk); #1;
        vec_cnt++;
        if (arready !== 1'b1) begin
            err_cnt++;
            $display("FAIL arready_after_reset: got %b expected 1", arready);
        end
        do_read(64'h2000, 8'd7, 1'b0, 1'b0);
        vec_cnt++;
        if (rd_cnt !== 8) begin
            err_cnt++;
            $display("FAIL reread_beats: got %0d expected 8", rd_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (rd_data[i] !== {16{32'h5EED_0000 + 32'(i)}}) begin
                err_cnt++;
                $display("FAIL reread_data[%0d]: got %h", i, rd_data[i]);
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        awvalid = 1'b0; awaddr = 64'd0; awid = 1'b0; awlen = 8'd0;
        wvalid = 1'b0; wdata = 512'd0; wstrb = 64'd0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = 64'd0; arid = 1'b0; arlen = 8'd0; rready = 1'b0;
        test_reset();
        test_burst();
        test_strobe();
        test_read_stall();
        test_wrap();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

On-chip AXI4 slave (responder) backed by a dual-port block RAM. It answers the full-width INCR read and write bursts issued by our kernel read/write masters, so kernels can run in hardware loopback and in simulation without external DDR/HBM. Read and write channels are handled by independent state machines sharing one memory array.
## Interface
- C_ADDR_WIDTH, 64, byte address width of awaddr/araddr
- C_DATA_WIDTH, 512, data bus width in bits; bytes per beat B = C_DATA_WIDTH/8, power of two
- C_ID_WIDTH, 1, AXI ID width
- C_MEM_DEPTH, 1024, memory depth in C_DATA_WIDTH words, power of two
- ap_clk  in  1  clock; all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  C_ADDR_WIDTH  burst start byte address
- awid  in  C_ID_WIDTH  write ID, echoed on bid
- awlen  in  8  beats minus one
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  C_DATA_WIDTH  write data
- wstrb  in  C_DATA_WIDTH/8  byte enables
- wlast  in  1  last write beat (informational)
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response
- bid  out  C_ID_WIDTH  captured awid
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  C_ADDR_WIDTH  burst start byte address
- arid  in  C_ID_WIDTH  read ID, echoed on rid
- arlen  in  8  beats minus one
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  C_DATA_WIDTH  read data
- rlast  out  1  last read beat
- rid  out  C_ID_WIDTH  captured arid
- rresp  out  2  read response
## Operation
- Word index = addr >> log2(B); low log2(B) address bits ignored. Every burst is INCR, full width; size/burst/cache fields are not ports and are not checked.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. W_IDLE: awready=1; AW handshake captures index, awid, beat count awlen+1. W_DATA: wready=1; each W handshake writes bytes where wstrb=1, index+1. Burst ends on beat counter, not wlast; a mismatched wlast is ignored. W_RESP: bvalid=1 until bready, bresp=OKAY.
- Read FSM R_IDLE -> R_FETCH -> R_DATA -> R_IDLE. R_IDLE: arready=1; AR handshake captures index, arid, count. R_FETCH: one cycle BRAM read. R_DATA: rvalid=1; next word prefetched so beats issue back-to-back; rlast=1 on beat arlen+1; after last handshake -> R_IDLE.
- Same-cycle read and write of the same word: read returns old data (read-first).
- One outstanding burst per direction; read and write proceed concurrently.
## Timing
- Reset: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0. Ready signals assert first cycle after areset deasserts. Memory contents not cleared.
- Reset mid-burst: both FSMs to idle next cycle, burst abandoned, no response issued.
- Read latency: AR handshake at cycle T -> first rvalid at T+2; then 1 beat/cycle while rready=1; rdata/rlast/rresp stable while rvalid & !rready. arready returns the cycle after last R handshake.
- Write: wready from cycle after AW handshake; bvalid cycle after last W beat; awready cycle after B handshake. Back-to-back single-beat writes: 1 burst per 3 cycles minimum.
## Configuration
- AXI_MEM_RESP_RANGE_CHK_EN defined: unwrapped word index >= C_MEM_DEPTH is out of range; such read beats return rdata=0, rresp=SLVERR (2'b10); such write beats are dropped and bresp=SLVERR if any beat was out of range. In-range beats behave normally.
- Not defined: word index wraps modulo C_MEM_DEPTH; all responses OKAY.
## Test plan
- Write awaddr=0x0, awlen=3, data 1..4, wstrb all ones; read araddr=0x0, arlen=3, rready=1 -> rdata 1,2,3,4, rlast on 4th, rvalid 2 cycles after AR handshake, bresp/rresp OKAY.
- Write one beat with wstrb=0x0F over word holding all 0xFF; read back -> low 4 bytes new, remaining bytes 0xFF.
- Read arlen=7 with rready toggling 1,0,0,1 -> 8 beats in order, data held stable while stalled, no beat lost or duplicated.
- awaddr = (C_MEM_DEPTH-1)*B, awlen=1: without macro second beat lands at word 0 and bresp=OKAY; with macro second beat dropped, bresp=SLVERR, word 0 unchanged.
- Assert areset during beat 3 of an 8-beat read -> rvalid=0 next cycle, arready=1 after reset release, new read returns previously written memory data.
